// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state and the
// stall/flush control bundle consumed by the PC and stage registers.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        REDIR = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic pc_sel;
        logic stall_pc;
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic flush_f;
        logic flush_d;
        logic flush_e;
        logic flush_m;
    } ctrl_sig_t;

endpackage

// File: rtl/hazard_ctrl_perf_cnt.sv
// Enabled free-running performance counter; wraps modulo 2^CNT_W.
module perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/redirect sequencing for the five-stage core, with a held
// redirect while an ibus fetch is outstanding and two performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic             i_data_ok,
    input  logic             d_valid,
    input  logic             d_data_ok,
    input  logic [4:0]       d_ra1,
    input  logic [4:0]       d_ra2,
    input  logic             d_use1,
    input  logic             d_use2,
    input  logic             e_is_load,
    input  logic [4:0]       e_rd,
    input  logic             e_redirect,
    input  logic [63:0]      e_target,
    output logic             pc_sel,
    output logic [63:0]      pc_target,
    output logic             stall_pc,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_f,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_redirect
);

    logic        imem_wait;
    logic        dmem_wait;
    logic        load_use;
    logic        redir_hold;
    ctrl_state_t state;
    ctrl_state_t state_nxt;
    logic [63:0] redir_tgt;
    ctrl_sig_t   ctrl;

    assign imem_wait = i_valid & ~i_data_ok;
    assign dmem_wait = d_valid & ~d_data_ok;
    assign load_use  = e_is_load & (e_rd != 5'd0) &
                       ((d_use1 & (d_ra1 == e_rd)) | (d_use2 & (d_ra2 == e_rd)));

    // A redirect can only be held when dbus is not freezing execute.
    assign redir_hold = (state == RUN) & ~dmem_wait & e_redirect & imem_wait;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            redir_tgt <= '0;
        end else begin
            state <= state_nxt;
            if (redir_hold)
                redir_tgt <= e_target;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (redir_hold) state_nxt = REDIR;
            REDIR:   if (!dmem_wait && !imem_wait) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        ctrl      = '0;
        pc_target = '0;
        if (!reset) begin
            ctrl.flush_f = 1'b1;
            ctrl.flush_d = 1'b1;
            ctrl.flush_e = 1'b1;
            ctrl.flush_m = 1'b1;
        end else begin
            pc_target = (state == REDIR) ? redir_tgt : e_target;
            if (dmem_wait) begin
                ctrl.stall_pc = 1'b1;
                ctrl.stall_f  = 1'b1;
                ctrl.stall_d  = 1'b1;
                ctrl.stall_e  = 1'b1;
                ctrl.flush_m  = 1'b1;
            end else if (state == REDIR) begin
                // Every word fetched here is wrong-path, including the one that completes.
                ctrl.flush_f = 1'b1;
                if (imem_wait)
                    ctrl.stall_pc = 1'b1;
                else
                    ctrl.pc_sel = 1'b1;
            end else if (e_redirect) begin
                ctrl.flush_f = 1'b1;
                ctrl.flush_d = 1'b1;
                if (imem_wait)
                    ctrl.stall_pc = 1'b1;
                else
                    ctrl.pc_sel = 1'b1;
            end else if (load_use) begin
                ctrl.stall_pc = 1'b1;
                ctrl.stall_f  = 1'b1;
                ctrl.flush_e  = 1'b1;
            end else if (imem_wait) begin
                ctrl.stall_pc = 1'b1;
                ctrl.flush_f  = 1'b1;
            end
        end
    end

    assign pc_sel   = ctrl.pc_sel;
    assign stall_pc = ctrl.stall_pc;
    assign stall_f  = ctrl.stall_f;
    assign stall_d  = ctrl.stall_d;
    assign stall_e  = ctrl.stall_e;
    assign flush_f  = ctrl.flush_f;
    assign flush_d  = ctrl.flush_d;
    assign flush_e  = ctrl.flush_e;
    assign flush_m  = ctrl.flush_m;

    perf_cnt #(.CNT_W(CNT_W)) u_cnt_stall (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl.stall_pc),
        .count (cnt_stall)
    );

    perf_cnt #(.CNT_W(CNT_W)) u_cnt_redirect (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl.pc_sel),
        .count (cnt_redirect)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a 32-bit counter instance for function and
// a 4-bit counter instance sharing the same stimulus for wrap behaviour.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        i_valid, i_data_ok, d_valid, d_data_ok;
    logic [4:0]  d_ra1, d_ra2, e_rd;
    logic        d_use1, d_use2, e_is_load, e_redirect;
    logic [63:0] e_target;

    logic        pc_sel, stall_pc, stall_f, stall_d, stall_e;
    logic        flush_f, flush_d, flush_e, flush_m;
    logic [63:0] pc_target;
    logic [31:0] cnt_stall, cnt_redirect;

    logic        pc_sel4, stall_pc4, stall_f4, stall_d4, stall_e4;
    logic        flush_f4, flush_d4, flush_e4, flush_m4;
    logic [63:0] pc_target4;
    logic [3:0]  cnt_stall4, cnt_redirect4;

    logic [8:0]  ctl, ctl4, exp_ctl;
    int          n_chk;
    int          n_fail;

    // {pc_sel, stall_pc, stall_f, stall_d, stall_e, flush_f, flush_d, flush_e, flush_m}
    assign ctl  = {pc_sel, stall_pc, stall_f, stall_d, stall_e, flush_f, flush_d, flush_e, flush_m};
    assign ctl4 = {pc_sel4, stall_pc4, stall_f4, stall_d4, stall_e4, flush_f4, flush_d4, flush_e4, flush_m4};

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_data_ok(i_data_ok), .d_valid(d_valid), .d_data_ok(d_data_ok),
        .d_ra1(d_ra1), .d_ra2(d_ra2), .d_use1(d_use1), .d_use2(d_use2),
        .e_is_load(e_is_load), .e_rd(e_rd), .e_redirect(e_redirect), .e_target(e_target),
        .pc_sel(pc_sel), .pc_target(pc_target),
        .stall_pc(stall_pc), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_f(flush_f), .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .cnt_stall(cnt_stall), .cnt_redirect(cnt_redirect)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_data_ok(i_data_ok), .d_valid(d_valid), .d_data_ok(d_data_ok),
        .d_ra1(d_ra1), .d_ra2(d_ra2), .d_use1(d_use1), .d_use2(d_use2),
        .e_is_load(e_is_load), .e_rd(e_rd), .e_redirect(e_redirect), .e_target(e_target),
        .pc_sel(pc_sel4), .pc_target(pc_target4),
        .stall_pc(stall_pc4), .stall_f(stall_f4), .stall_d(stall_d4), .stall_e(stall_e4),
        .flush_f(flush_f4), .flush_d(flush_d4), .flush_e(flush_e4), .flush_m(flush_m4),
        .cnt_stall(cnt_stall4), .cnt_redirect(cnt_redirect4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        i_valid = 0; i_data_ok = 0; d_valid = 0; d_data_ok = 0;
        d_ra1 = 0; d_ra2 = 0; d_use1 = 0; d_use2 = 0;
        e_is_load = 0; e_rd = 0; e_redirect = 0; e_target = 64'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b0_0000_1111) begin
            n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 9'b0_0000_1111);
        end
        n_chk++;
        if (pc_target !== 64'h0) begin
            n_fail++; $display("FAIL reset_pc_target got=%h exp=0", pc_target);
        end
        n_chk++;
        if (cnt_stall !== 32'd0 || cnt_redirect !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cnt_stall, cnt_redirect);
        end
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b0) begin
            n_fail++; $display("FAIL idle_ctl got=%b exp=%b", ctl, 9'b0);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        e_is_load = 1; e_rd = 5; d_use1 = 1; d_ra1 = 5;
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b0_1100_0010) begin
            n_fail++; $display("FAIL lu_ra1 got=%b exp=%b", ctl, 9'b0_1100_0010);
        end
        next_cycle();
        e_rd = 0; d_ra1 = 0;
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b0) begin
            n_fail++; $display("FAIL lu_rd0 got=%b exp=%b", ctl, 9'b0);
        end
        next_cycle();
        e_rd = 7; d_use1 = 0; d_ra1 = 7; d_use2 = 1; d_ra2 = 7;
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b0_1100_0010) begin
            n_fail++; $display("FAIL lu_ra2 got=%b exp=%b", ctl, 9'b0_1100_0010);
        end
        next_cycle();
        d_use2 = 0;
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b0) begin
            n_fail++; $display("FAIL lu_nouse got=%b exp=%b", ctl, 9'b0);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if (cnt_stall !== 32'd2) begin
            n_fail++; $display("FAIL lu_cnt_stall got=%0d exp=2", cnt_stall);
        end
        next_cycle();
    endtask

    task automatic test_redirect_idle();
        e_redirect = 1; e_target = 64'h8000_0040; i_valid = 1; i_data_ok = 1;
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b1_0000_1100) begin
            n_fail++; $display("FAIL redir_idle_ctl got=%b exp=%b", ctl, 9'b1_0000_1100);
        end
        n_chk++;
        if (pc_target !== 64'h8000_0040) begin
            n_fail++; $display("FAIL redir_idle_tgt got=%h exp=%h", pc_target, 64'h8000_0040);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b0 || cnt_redirect !== 32'd1 || cnt_stall !== 32'd2) begin
            n_fail++; $display("FAIL redir_idle_after ctl=%b redir=%0d stall=%0d exp=0/1/2", ctl, cnt_redirect, cnt_stall);
        end
        next_cycle();
    endtask

    task automatic test_redirect_fetch();
        i_valid = 1; i_data_ok = 0; e_redirect = 1; e_target = 64'h8000_0100;
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b0_1000_1100) begin
            n_fail++; $display("FAIL redir_fetch_c0 got=%b exp=%b", ctl, 9'b0_1000_1100);
        end
        next_cycle();
        e_redirect = 0; e_target = 64'h0000_1234;
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b0_1000_1000) begin
            n_fail++; $display("FAIL redir_fetch_c1 got=%b exp=%b", ctl, 9'b0_1000_1000);
        end
        next_cycle();
        // A younger redirect while held must be ignored
        e_redirect = 1; e_target = 64'hdead_0000;
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b0_1000_1000) begin
            n_fail++; $display("FAIL redir_fetch_c2 got=%b exp=%b", ctl, 9'b0_1000_1000);
        end
        next_cycle();
        e_redirect = 0; i_data_ok = 1;
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b1_0000_1000) begin
            n_fail++; $display("FAIL redir_fetch_done got=%b exp=%b", ctl, 9'b1_0000_1000);
        end
        n_chk++;
        if (pc_target !== 64'h8000_0100) begin
            n_fail++; $display("FAIL redir_fetch_tgt got=%h exp=%h", pc_target, 64'h8000_0100);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b0 || cnt_stall !== 32'd5 || cnt_redirect !== 32'd2) begin
            n_fail++; $display("FAIL redir_fetch_after ctl=%b stall=%0d redir=%0d exp=0/5/2", ctl, cnt_stall, cnt_redirect);
        end
        next_cycle();
    endtask

    task automatic test_dbus_wait();
        d_valid = 1; d_data_ok = 0;
        e_is_load = 1; e_rd = 9; d_use1 = 1; d_ra1 = 9;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if (ctl !== 9'b0_1111_0001) begin
                n_fail++; $display("FAIL dbus_c%0d got=%b exp=%b", i, ctl, 9'b0_1111_0001);
            end
            next_cycle();
        end
        n_chk++;
        if (cnt_stall !== 32'd9) begin
            n_fail++; $display("FAIL dbus_cnt got=%0d exp=9", cnt_stall);
        end
        // dbus and ibus wait together: dbus rules win
        e_is_load = 0; d_use1 = 0; i_valid = 1; i_data_ok = 0;
        e_redirect = 1; e_target = 64'h8000_0300;
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b0_1111_0001) begin
            n_fail++; $display("FAIL dbus_ibus got=%b exp=%b", ctl, 9'b0_1111_0001);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b0 || cnt_stall !== 32'd10 || cnt_redirect !== 32'd2) begin
            n_fail++; $display("FAIL dbus_after ctl=%b stall=%0d redir=%0d exp=0/10/2", ctl, cnt_stall, cnt_redirect);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_redir();
        i_valid = 1; i_data_ok = 0; e_redirect = 1; e_target = 64'h8000_0200;
        next_cycle();
        e_redirect = 0;
        #1;
        n_chk++;
        if (ctl !== 9'b0_1000_1000) begin
            n_fail++; $display("FAIL mid_redir_held got=%b exp=%b", ctl, 9'b0_1000_1000);
        end
        reset = 1'b0;
        #1;
        n_chk++;
        if (ctl !== 9'b0_0000_1111 || pc_target !== 64'h0) begin
            n_fail++; $display("FAIL mid_redir_async ctl=%b tgt=%h exp=%b/0", ctl, pc_target, 9'b0_0000_1111);
        end
        n_chk++;
        if (cnt_stall !== 32'd0 || cnt_redirect !== 32'd0) begin
            n_fail++; $display("FAIL mid_redir_cnt got=%0d/%0d exp=0/0", cnt_stall, cnt_redirect);
        end
        @(negedge clk);
        reset = 1'b1;
        i_valid = 0;
        next_cycle();
        @(negedge clk);
        n_chk++;
        if (ctl !== 9'b0 || cnt_redirect !== 32'd0) begin
            n_fail++; $display("FAIL mid_redir_stale ctl=%b redir=%0d exp=0/0", ctl, cnt_redirect);
        end
        next_cycle();
    endtask

    task automatic test_counter_wrap();
        idle_inputs();
        e_target = 64'h0000_0000_4000_0000;
        i_valid = 1; i_data_ok = 0;
        for (int i = 0; i < 17; i++)
            next_cycle();
        @(negedge clk);
        n_chk++;
        if (ctl4 !== 9'b0_1000_1000 || pc_target4 !== 64'h0000_0000_4000_0000) begin
            n_fail++; $display("FAIL wrap_ctl4 ctl=%b tgt=%h exp=%b/40000000", ctl4, pc_target4, 9'b0_1000_1000);
        end
        n_chk++;
        if (cnt_stall4 !== 4'd1 || cnt_redirect4 !== 4'd0) begin
            n_fail++; $display("FAIL wrap_cnt4 got=%0d/%0d exp=1/0", cnt_stall4, cnt_redirect4);
        end
        n_chk++;
        if (cnt_stall !== 32'd17) begin
            n_fail++; $display("FAIL wrap_cnt32 got=%0d exp=17", cnt_stall);
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_load_use();
        test_redirect_idle();
        test_redirect_fetch();
        test_dbus_wait();
        test_reset_mid_redir();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
